// File: rtl/tlu_cmd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlu_cmd_arbiter_pkg
// Brief    : Shared encodings and widths for the TLU command-start arbiter.
// Revision : 1.0
// ============================================================================
package tlu_cmd_arbiter_pkg;

    localparam logic [2:0] ST_IDLE           = 3'd0;
    localparam logic [2:0] ST_START          = 3'd1;
    localparam logic [2:0] ST_WAIT_CMD_BUSY  = 3'd2;
    localparam logic [2:0] ST_WAIT_CMD_READY = 3'd3;
    localparam logic [2:0] ST_RELEASE        = 3'd4;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    localparam int TRIG_CNT_W  = 32;
    localparam int ABORT_CNT_W = 8;
    localparam int TIMEOUT_W   = 8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlu_cmd_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Selects one eligible requester, fixed priority or round robin.
// Revision : 1.0
// ============================================================================
module rr_picker
    import tlu_cmd_arbiter_pkg::*;
#(
    parameter  int NREQ = 3,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [PW-1:0]   i_ptr,
    input  logic            i_arb_mode,
    output logic [NREQ-1:0] o_onehot,
    output logic [PW-1:0]   o_idx
);

    logic [PW:0] w_j;
    logic        w_found;

    // Scan starts at the pointer in round-robin mode, at 0 otherwise.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_j      = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_j = (i_arb_mode == ARB_RR) ? ({1'b0, i_ptr} + (PW+1)'(i)) : (PW+1)'(i);
            if (w_j >= (PW+1)'(NREQ)) begin
                w_j = w_j - (PW+1)'(NREQ);
            end
            if (!w_found && i_elig[w_j[PW-1:0]]) begin
                w_found                 = 1'b1;
                o_onehot[w_j[PW-1:0]]   = 1'b1;
                o_idx                   = w_j[PW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tlu_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tlu_cmd_arbiter
// Brief    : Shares the command-start resource among trigger requesters.
// Revision : 1.0
// ============================================================================
module tlu_cmd_arbiter
    import tlu_cmd_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IDW  = 3
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [NREQ-1:0]        REQ,
    input  logic [NREQ-1:0]        REQ_MASK,
    input  logic                   ARB_MODE,
    input  logic                   CMD_EXT_START_ENABLE,
    input  logic                   FIFO_NEAR_FULL,
    input  logic                   CMD_READY,
    input  logic [TIMEOUT_W-1:0]   CMD_READY_TIME_OUT,
    output logic                   CMD_EXT_START_FLAG,
    output logic [NREQ-1:0]        GNT,
    output logic [IDW-1:0]         GNT_ID,
    output logic [NREQ-1:0]        DONE,
    output logic [NREQ-1:0]        ABORT,
    output logic                   BUSY,
    output logic [TRIG_CNT_W-1:0]  TRIGGER_COUNT,
    output logic [ABORT_CNT_W-1:0] ABORT_COUNT
);

    localparam int PW = $clog2(NREQ);

    logic [2:0]             state_q, state_d;
    logic [NREQ-1:0]        gnt_q, gnt_d;
    logic [IDW-1:0]         gnt_id_q, gnt_id_d;
    logic                   flag_q, flag_d;
    logic [NREQ-1:0]        done_q, done_d;
    logic [NREQ-1:0]        abort_q, abort_d;
    logic                   busy_q, busy_d;
    logic [TRIG_CNT_W-1:0]  trigger_count_q, trigger_count_d;
    logic [ABORT_CNT_W-1:0] abort_count_q, abort_count_d;
    logic [TIMEOUT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [PW-1:0]          ptr_q, ptr_d;

    logic [NREQ-1:0]        w_elig;
    logic [NREQ-1:0]        w_win_onehot;
    logic [PW-1:0]          w_win_idx;
    logic                   w_grant_ok;

    assign w_elig     = REQ & ~REQ_MASK;
    assign w_grant_ok = (|w_elig) && CMD_EXT_START_ENABLE && !FIFO_NEAR_FULL && CMD_READY;

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .i_elig     (w_elig),
        .i_ptr      (ptr_q),
        .i_arb_mode (ARB_MODE),
        .o_onehot   (w_win_onehot),
        .o_idx      (w_win_idx)
    );

    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        gnt_id_d        = gnt_id_q;
        flag_d          = 1'b0;
        done_d          = '0;
        abort_d         = '0;
        trigger_count_d = trigger_count_q;
        abort_count_d   = abort_count_q;
        ptr_d           = ptr_q;
        tmo_cnt_d       = (state_q == ST_WAIT_CMD_BUSY) ? sat_inc8(tmo_cnt_q) : '0;

        case (state_q)
            ST_IDLE: begin
                if (w_grant_ok) begin
                    state_d  = ST_START;
                    gnt_d    = w_win_onehot;
                    gnt_id_d = IDW'(w_win_idx);
                    flag_d   = 1'b1;
                    ptr_d    = (w_win_idx == PW'(NREQ-1)) ? '0 : w_win_idx + PW'(1);
                end
            end
            ST_START: begin
                state_d = ST_WAIT_CMD_BUSY;
            end
            ST_WAIT_CMD_BUSY: begin
                if (!CMD_READY) begin
                    state_d = ST_WAIT_CMD_READY;
                end else if ((CMD_READY_TIME_OUT != '0) && (tmo_cnt_q >= CMD_READY_TIME_OUT)) begin
                    state_d       = ST_RELEASE;
                    abort_d       = gnt_q;
                    abort_count_d = sat_inc8(abort_count_q);
                end
            end
            ST_WAIT_CMD_READY: begin
                if (CMD_READY) begin
                    state_d         = ST_RELEASE;
                    done_d          = gnt_q;
                    trigger_count_d = trigger_count_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                // Leave only once the granted requester has withdrawn its request.
                if ((REQ & gnt_q) == '0) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q         <= ST_IDLE;
            gnt_q           <= '0;
            gnt_id_q        <= '0;
            flag_q          <= 1'b0;
            done_q          <= '0;
            abort_q         <= '0;
            busy_q          <= 1'b0;
            trigger_count_q <= '0;
            abort_count_q   <= '0;
            tmo_cnt_q       <= '0;
            ptr_q           <= '0;
        end else begin
            state_q         <= state_d;
            gnt_q           <= gnt_d;
            gnt_id_q        <= gnt_id_d;
            flag_q          <= flag_d;
            done_q          <= done_d;
            abort_q         <= abort_d;
            busy_q          <= busy_d;
            trigger_count_q <= trigger_count_d;
            abort_count_q   <= abort_count_d;
            tmo_cnt_q       <= tmo_cnt_d;
            ptr_q           <= ptr_d;
        end
    end

    assign CMD_EXT_START_FLAG = flag_q;
    assign GNT                = gnt_q;
    assign GNT_ID             = gnt_id_q;
    assign DONE               = done_q;
    assign ABORT              = abort_q;
    assign BUSY               = busy_q;
    assign TRIGGER_COUNT      = trigger_count_q;
    assign ABORT_COUNT        = abort_count_q;

endmodule
`default_nettype wire

// File: tb/tb_tlu_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlu_cmd_arbiter
// Brief    : Directed plus randomized bench for tlu_cmd_arbiter.
// Revision : 1.0
// ============================================================================
module tb_tlu_cmd_arbiter;

    localparam int NREQ = 3;
    localparam int IDW  = 3;

    logic            CLK = 1'b0;
    logic            RESET_N;
    logic [NREQ-1:0] REQ;
    logic [NREQ-1:0] REQ_MASK;
    logic            ARB_MODE;
    logic            CMD_EXT_START_ENABLE;
    logic            FIFO_NEAR_FULL;
    logic            CMD_READY;
    logic [7:0]      CMD_READY_TIME_OUT;
    logic            CMD_EXT_START_FLAG;
    logic [NREQ-1:0] GNT;
    logic [IDW-1:0]  GNT_ID;
    logic [NREQ-1:0] DONE;
    logic [NREQ-1:0] ABORT;
    logic            BUSY;
    logic [31:0]     TRIGGER_COUNT;
    logic [7:0]      ABORT_COUNT;

    tlu_cmd_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .CLK                  (CLK),
        .RESET_N              (RESET_N),
        .REQ                  (REQ),
        .REQ_MASK             (REQ_MASK),
        .ARB_MODE             (ARB_MODE),
        .CMD_EXT_START_ENABLE (CMD_EXT_START_ENABLE),
        .FIFO_NEAR_FULL       (FIFO_NEAR_FULL),
        .CMD_READY            (CMD_READY),
        .CMD_READY_TIME_OUT   (CMD_READY_TIME_OUT),
        .CMD_EXT_START_FLAG   (CMD_EXT_START_FLAG),
        .GNT                  (GNT),
        .GNT_ID               (GNT_ID),
        .DONE                 (DONE),
        .ABORT                (ABORT),
        .BUSY                 (BUSY),
        .TRIGGER_COUNT        (TRIGGER_COUNT),
        .ABORT_COUNT          (ABORT_COUNT)
    );

    always #5 CLK = ~CLK;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          ref_ptr;
    logic [31:0] ref_trig;
    int          ref_abort;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: lowest index, or first index at/after ptr with wrap.
    function automatic int model_pick(input logic [2:0] e, input logic mode, input int ptr);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = mode ? (ptr + k) % NREQ : k;
            if (e[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flag"}, CMD_EXT_START_FLAG, 0);
        chk({tag, "_gnt"}, GNT, 0);
        chk({tag, "_gnt_id"}, GNT_ID, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_abort"}, ABORT, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_trig"}, TRIGGER_COUNT, 0);
        chk({tag, "_abcnt"}, ABORT_COUNT, 0);
    endtask

    // One full transaction; called at a negedge with the DUT idle and a grant pending.
    task automatic do_txn(input int exp_w, input bit ab, input int tmo, input int bd,
                          input int len, input int hold, input bit early, input bit disturb);
        int          w;
        int          lat;
        int          end_cyc;
        logic [2:0]  oh;
        logic [2:0]  sv_mask;
        logic        sv_en;
        logic        sv_ff;
        w = (exp_w >= 0) ? exp_w : model_pick(REQ & ~REQ_MASK, ARB_MODE, ref_ptr);
        oh = (w >= 0) ? 3'(1 << w) : 3'b000;
        sv_mask = REQ_MASK;
        sv_en   = CMD_EXT_START_ENABLE;
        sv_ff   = FIFO_NEAR_FULL;
        CMD_READY_TIME_OUT = 8'(tmo);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!CMD_EXT_START_FLAG && lat < 20);
        chk("grant_latency", lat, 1);
        if (!CMD_EXT_START_FLAG) return;
        chk("gnt", GNT, oh);
        chk("gnt_id", GNT_ID, w);
        chk("busy_start", BUSY, 1);
        chk("done_abort_start", DONE | ABORT, 0);
        ref_ptr = (w + 1) % NREQ;
        end_cyc = ab ? tmo + 2 : bd + len + 1;
        for (int cyc = 1; cyc <= end_cyc; cyc++) begin
            @(negedge CLK);
            if (cyc == end_cyc) begin
                if (ab) begin
                    if (ref_abort < 255) ref_abort++;
                end else begin
                    ref_trig = ref_trig + 32'd1;
                end
            end
            chk("flag_one_cycle", CMD_EXT_START_FLAG, 0);
            chk("gnt_hold", GNT, oh);
            chk("busy_hold", BUSY, 1);
            chk("done", DONE, (!ab && cyc == end_cyc) ? oh : 3'b000);
            chk("abort", ABORT, (ab && cyc == end_cyc) ? oh : 3'b000);
            chk("trigger_count", TRIGGER_COUNT, ref_trig);
            chk("abort_count", ABORT_COUNT, ref_abort);
            if (!ab && cyc == bd) CMD_READY = 1'b0;
            if (!ab && cyc == bd + len) CMD_READY = 1'b1;
            if (early && cyc == 1) REQ = REQ & ~oh;
            if (disturb && cyc == 1) begin
                CMD_EXT_START_ENABLE = 1'b0;
                FIFO_NEAR_FULL       = 1'b1;
                REQ_MASK             = 3'b111;
            end
            if (disturb && cyc == end_cyc) begin
                CMD_EXT_START_ENABLE = sv_en;
                FIFO_NEAR_FULL       = sv_ff;
                REQ_MASK             = sv_mask;
            end
        end
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge CLK);
                chk("release_gnt_hold", GNT, oh);
                chk("release_busy", BUSY, 1);
                chk("release_pulses", DONE | ABORT, 0);
            end
        end
        REQ = REQ & ~oh;
        @(negedge CLK);
        chk("idle_gnt", GNT, 0);
        chk("idle_busy", BUSY, 0);
        chk("idle_flag", CMD_EXT_START_FLAG, 0);
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk({tag, "_flag"}, CMD_EXT_START_FLAG, 0);
            chk({tag, "_busy"}, BUSY, 0);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bd;
        int tmo;
        RESET_N              = 1'b0;
        REQ                  = '0;
        REQ_MASK             = '0;
        ARB_MODE             = 1'b0;
        CMD_EXT_START_ENABLE = 1'b1;
        FIFO_NEAR_FULL       = 1'b0;
        CMD_READY            = 1'b1;
        CMD_READY_TIME_OUT   = '0;
        ref_ptr   = 0;
        ref_trig  = '0;
        ref_abort = 0;
        repeat (3) @(negedge CLK);
        chk_all_zero("reset");
        RESET_N = 1'b1;
        @(negedge CLK);

        // Single request with the canonical command timing.
        REQ = 3'b001;
        do_txn(0, 0, 0, 1, 4, 0, 0, 0);

        // Simultaneous requests, fixed priority.
        REQ = 3'b111;
        do_txn(0, 0, 0, 1, 2, 0, 0, 0);
        do_txn(1, 0, 0, 2, 1, 1, 0, 0);
        do_txn(2, 0, 0, 1, 1, 0, 0, 0);

        // Move the pointer to 2, then round robin from there.
        REQ = 3'b010;
        do_txn(1, 0, 0, 1, 1, 0, 0, 0);
        ARB_MODE = 1'b1;
        REQ = 3'b111;
        do_txn(2, 0, 0, 1, 3, 0, 0, 0);
        do_txn(0, 0, 0, 1, 1, 0, 0, 0);
        do_txn(1, 0, 0, 3, 2, 0, 0, 0);

        // Timeout abort, then no abort with timeout disabled.
        ARB_MODE = 1'b0;
        REQ = 3'b001;
        do_txn(0, 1, 5, 0, 0, 0, 0, 0);
        REQ = 3'b010;
        do_txn(1, 0, 0, 1000, 2, 0, 0, 0);

        // Busy seen on exactly the edge the timeout would fire.
        REQ = 3'b100;
        do_txn(2, 0, 4, 5, 2, 0, 0, 0);

        // Gating by FIFO_NEAR_FULL and CMD_EXT_START_ENABLE.
        REQ = 3'b010;
        FIFO_NEAR_FULL = 1'b1;
        idle_cycles("gate_fifo", 6);
        FIFO_NEAR_FULL = 1'b0;
        do_txn(1, 0, 0, 1, 1, 0, 0, 0);
        REQ = 3'b010;
        CMD_EXT_START_ENABLE = 1'b0;
        idle_cycles("gate_enable", 6);
        CMD_EXT_START_ENABLE = 1'b1;
        do_txn(1, 0, 0, 2, 2, 0, 0, 0);

        // Masked requester is never granted.
        REQ = 3'b010;
        REQ_MASK = 3'b010;
        idle_cycles("mask", 8);
        REQ = 3'b011;
        do_txn(0, 0, 0, 1, 1, 0, 0, 0);
        idle_cycles("mask_after", 5);
        REQ_MASK = 3'b000;
        do_txn(1, 0, 0, 1, 1, 0, 0, 0);

        // Early REQ drop and mid-transaction gate changes.
        REQ = 3'b100;
        do_txn(2, 0, 3, 2, 3, 0, 1, 1);
        REQ = 3'b001;
        do_txn(0, 1, 2, 0, 0, 3, 0, 1);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 80; t++) begin
            REQ = REQ | 3'($urandom_range(0, 7));
            if (REQ == 3'b000) REQ = 3'($urandom_range(1, 7));
            REQ_MASK = 3'($urandom_range(0, 7));
            if ((REQ & ~REQ_MASK) == 3'b000) REQ_MASK = 3'b000;
            ARB_MODE = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                do_txn(-1, 1, $urandom_range(1, 6), 0, 0, $urandom_range(0, 2), 0, $urandom_range(0, 1));
            end else begin
                bd  = $urandom_range(1, 4);
                tmo = ($urandom_range(0, 1) == 0) ? 0 : bd - 1 + $urandom_range(0, 4);
                do_txn(-1, 0, tmo, bd, $urandom_range(1, 5), $urandom_range(0, 2),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 1));
            end
        end

        // TRIGGER_COUNT wrap.
        REQ      = 3'b000;
        REQ_MASK = 3'b000;
        ARB_MODE = 1'b0;
        force dut.trigger_count_q = 32'hFFFF_FFFE;
        @(negedge CLK);
        release dut.trigger_count_q;
        ref_trig = 32'hFFFF_FFFE;
        REQ = 3'b001;
        do_txn(0, 0, 0, 1, 1, 0, 0, 0);
        REQ = 3'b001;
        do_txn(0, 0, 0, 1, 1, 0, 0, 0);
        chk("trigger_wrap", TRIGGER_COUNT, 0);

        // ABORT_COUNT saturation.
        for (int i = 0; i < 300; i++) begin
            REQ = 3'b001;
            do_txn(0, 1, 1, 0, 0, 0, 0, 0);
        end
        chk("abort_saturate", ABORT_COUNT, 255);

        // Reset in WAIT_CMD_READY.
        REQ = 3'b001;
        @(negedge CLK);
        chk("rst_flag", CMD_EXT_START_FLAG, 1);
        @(negedge CLK);
        CMD_READY = 1'b0;
        @(negedge CLK);
        chk("rst_busy_before", BUSY, 1);
        RESET_N = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        REQ       = 3'b000;
        CMD_READY = 1'b1;
        @(negedge CLK);
        RESET_N   = 1'b1;
        ref_ptr   = 0;
        ref_trig  = '0;
        ref_abort = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("post_reset_done", DONE, 0);
            chk("post_reset_busy", BUSY, 0);
            chk("post_reset_trig", TRIGGER_COUNT, 0);
        end

        // Pointer restarts at 0 after reset.
        ARB_MODE = 1'b1;
        REQ = 3'b111;
        do_txn(0, 0, 0, 1, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
